// File: rtl/cnt_seq_ctrl.sv
// Programmable up/down counter sequencer: runs a number of start-to-limit passes
// with pause (HOLD) and abort, then pulses done for one cycle.
module cnt_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_reps,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] r_pass;
    logic [WIDTH-1:0] w_pass_next;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_limit;
    logic             r_dir;
    logic [WIDTH-1:0] r_reps;

    logic             w_accept;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_q_step;

    // Ready is masked by reset so nothing can be accepted on a reset edge.
    assign cmd_ready  = (r_state == S_IDLE) & ~reset;
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_at_limit = (r_q == r_limit);
    assign w_q_step   = r_dir ? (r_q + WIDTH'(1)) : (r_q - WIDTH'(1));

    assign q    = r_q;
    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign tc   = (r_state == S_RUN) & w_at_limit & ~pause & ~abort;

    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_pass_next  = r_pass;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                    w_q_next     = cmd_start;
                    w_pass_next  = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_q_next     = '0;
                    w_pass_next  = '0;
                end else if (pause) begin
                    w_state_next = S_HOLD;
                end else if (!w_at_limit) begin
                    w_q_next = w_q_step;
                end else if (r_pass == r_reps) begin
                    w_state_next = S_DONE;
                end else begin
                    w_pass_next = r_pass + WIDTH'(1);
                    w_q_next    = r_start;
                end
            end
            S_HOLD: begin
                // Resuming costs one cycle with q held; counting restarts in RUN.
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_q_next     = '0;
                    w_pass_next  = '0;
                end else if (!pause) begin
                    w_state_next = S_RUN;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_pass  <= '0;
            r_start <= '0;
            r_limit <= '0;
            r_dir   <= 1'b0;
            r_reps  <= '0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_pass  <= w_pass_next;
            if (w_accept) begin
                r_start <= cmd_start;
                r_limit <= cmd_limit;
                r_dir   <= cmd_dir;
                r_reps  <= cmd_reps;
            end
        end
    end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: directed scenarios with literal traces plus random
// stimulus, all cycles compared against a behavioural model of the sequencer.
module tb_cnt_seq_ctrl;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_start;
    logic [W-1:0] cmd_limit;
    logic         cmd_dir;
    logic [W-1:0] cmd_reps;
    logic         pause;
    logic         abort;
    logic [W-1:0] q;
    logic         tc;
    logic         done;
    logic         busy;

    always #5 clk = ~clk;

    cnt_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_limit (cmd_limit),
        .cmd_dir   (cmd_dir),
        .cmd_reps  (cmd_reps),
        .pause     (pause),
        .abort     (abort),
        .q         (q),
        .tc        (tc),
        .done      (done),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Behavioural model: run mode, count value, pass index, latched command.
    localparam int M_IDLE   = 0;
    localparam int M_COUNT  = 1;
    localparam int M_PAUSED = 2;
    localparam int M_FINISH = 3;

    int m_mode  = M_IDLE;
    int m_q     = 0;
    int m_pass  = 0;
    int m_start = 0;
    int m_limit = 0;
    int m_dir   = 0;
    int m_reps  = 0;
    bit m_known = 1'b0;

    // Inputs only change at posedge+1, so they are stable at the negedge where
    // outputs are compared and the model advances to the upcoming edge.
    always @(negedge clk) begin
        if (m_known) begin
            chk("model_q", int'(q), m_q);
            chk("model_busy", int'(busy), int'(m_mode != M_IDLE));
            chk("model_done", int'(done), int'(m_mode == M_FINISH));
            chk("model_ready", int'(cmd_ready), int'(m_mode == M_IDLE && !reset));
            chk("model_tc", int'(tc),
                int'(m_mode == M_COUNT && m_q == m_limit && !pause && !abort));
        end
        if (reset) begin
            m_known = 1'b1;
            m_mode  = M_IDLE;
            m_q     = 0;
            m_pass  = 0;
            m_start = 0;
            m_limit = 0;
            m_dir   = 0;
            m_reps  = 0;
        end else if (m_known) begin
            if (m_mode == M_IDLE) begin
                if (cmd_valid) begin
                    m_start = int'(cmd_start);
                    m_limit = int'(cmd_limit);
                    m_dir   = int'(cmd_dir);
                    m_reps  = int'(cmd_reps);
                    m_q     = m_start;
                    m_pass  = 0;
                    m_mode  = M_COUNT;
                    $display("accept start=%0d limit=%0d dir=%0d reps=%0d",
                             m_start, m_limit, m_dir, m_reps);
                end
            end else if (m_mode == M_FINISH) begin
                m_mode = M_IDLE;
            end else if (abort) begin
                m_mode = M_IDLE;
                m_q    = 0;
                m_pass = 0;
            end else if (m_mode == M_PAUSED) begin
                if (!pause) m_mode = M_COUNT;
            end else if (pause) begin
                m_mode = M_PAUSED;
            end else if (m_q != m_limit) begin
                m_q = (m_q + (m_dir != 0 ? 1 : -1)) & MASK;
            end else if (m_pass == m_reps) begin
                m_mode = M_FINISH;
            end else begin
                m_pass = m_pass + 1;
                m_q    = m_start;
            end
        end
    end

    int tq[$];
    int ttc[$];
    int tdone[$];
    int tbusy[$];
    int exp_q[$];
    int exp_tc[$];
    int exp_done[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int s, int l, int d, int r);
        tick();
        cmd_valid = 1'b1;
        cmd_start = W'(s);
        cmd_limit = W'(l);
        cmd_dir   = d[0];
        cmd_reps  = W'(r);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic capture(int n);
        tq.delete();
        ttc.delete();
        tdone.delete();
        tbusy.delete();
        repeat (n) begin
            @(negedge clk);
            tq.push_back(int'(q));
            ttc.push_back(int'(tc));
            tdone.push_back(int'(done));
            tbusy.push_back(int'(busy));
        end
    endtask

    task automatic check_trace(string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_q%0d", tag, i), tq[i], exp_q[i]);
            chk($sformatf("%s_tc%0d", tag, i), ttc[i], exp_tc[i]);
            chk($sformatf("%s_done%0d", tag, i), tdone[i], exp_done[i]);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_limit = '0;
        cmd_dir   = 1'b0;
        cmd_reps  = '0;
        pause     = 1'b0;
        abort     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_ready", int'(cmd_ready), 1);

        // Single pass up
        send(3, 6, 1, 0);
        capture(6);
        exp_q    = '{3, 4, 5, 6, 6, 6};
        exp_tc   = '{0, 0, 0, 1, 0, 0};
        exp_done = '{0, 0, 0, 0, 1, 0};
        check_trace("up");
        chk("up_busy_end", tbusy[5], 0);

        // Down with wrap
        send(1, 14, 0, 0);
        capture(6);
        exp_q    = '{1, 0, 15, 14, 14, 14};
        exp_tc   = '{0, 0, 0, 1, 0, 0};
        exp_done = '{0, 0, 0, 0, 1, 0};
        check_trace("down");

        // Three passes
        send(0, 2, 1, 2);
        capture(11);
        exp_q    = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 2, 2};
        exp_tc   = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        exp_done = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        check_trace("reps");

        // start == limit: every pass is a single tc cycle
        send(7, 7, 0, 1);
        capture(4);
        exp_q    = '{7, 7, 7, 7};
        exp_tc   = '{1, 1, 0, 0};
        exp_done = '{0, 0, 1, 0};
        check_trace("eq");

        // Pause for three cycles starting at q=4
        send(3, 6, 1, 0);
        tick();
        pause = 1'b1;
        tick();
        tick();
        tick();
        pause = 1'b0;
        capture(6);
        chk("pause_q2", tq[2], 5);
        chk("pause_q3", tq[3], 6);
        chk("pause_tc3", ttc[3], 1);
        chk("pause_done4", tdone[4], 1);
        chk("pause_busy5", tbusy[5], 0);

        // Command while busy is ignored; abort while paused
        send(3, 9, 1, 0);
        cmd_valid = 1'b1;
        cmd_start = W'(0);
        cmd_limit = W'(4);
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("ign_q", int'(q), 4);
        chk("ign_tc", int'(tc), 0);
        tick();
        pause = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pause = 1'b0;
        capture(3);
        chk("abort_q", tq[0], 0);
        chk("abort_busy", tbusy[0], 0);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_nodone", tdone[0] + tdone[1] + tdone[2], 0);

        // Reset mid-run at q=5
        send(3, 9, 1, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("mrst_q", int'(q), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_tc", int'(tc), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_ready", int'(cmd_ready), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_ready_after", int'(cmd_ready), 1);

        // Random traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            tick();
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_start = W'($urandom);
            cmd_limit = ($urandom_range(0, 3) == 0) ? cmd_start : W'($urandom);
            cmd_dir   = 1'($urandom);
            cmd_reps  = ($urandom_range(0, 9) == 0) ? W'(MASK) : W'($urandom_range(0, 3));
            pause     = ($urandom_range(0, 9) == 0);
            abort     = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 299) == 0);
        end
        tick();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        pause     = 1'b0;
        abort     = 1'b0;
        tick();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
